// File: rtl/pic_bus_pkg.sv
// Shared definitions for the 8259A bus initiator.
//   - bus_state_e : single-transaction timing FSM encoding
//   - ICW1 bit positions used by the initialization sequencer
//   - legal timing-parameter range and counter width
package pic_bus_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StRecover
    } bus_state_e;

    // ICW1 bit positions
    localparam int unsigned IC4     = 0;
    localparam int unsigned SNGL    = 1;
    localparam int unsigned ICW1_ID = 4;

    // Legal range of every timing parameter
    localparam int unsigned MinCycles = 1;
    localparam int unsigned MaxCycles = 15;
    localparam int unsigned CntW      = $clog2(16);

    // Phase counters count down from cycles-1 to zero.
    function automatic logic [CntW-1:0] load_cnt(input int unsigned cycles);
        return CntW'(cycles - 1);
    endfunction

endpackage

// File: rtl/pic_bus_cycle_gen.sv
// Single-transaction bus timing generator: IDLE -> SETUP -> STROBE -> RECOVER -> IDLE.
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   start                   : begin a transaction (honoured in IDLE only)
//   write, a0, wdata        : transaction attributes, latched on start
//   idle                    : FSM is in IDLE
//   last_recover            : final RECOVER cycle of the current transaction
//   chip_select_n, read_enable_n, write_enable_n, address : bus control
//   data_bus_out, data_bus_oe, data_bus_in                : data bus
//   rsp_valid, rsp_data     : read data pulse / held read data
module pic_bus_cycle_gen
    import pic_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES    = 1,
    parameter int unsigned STROBE_CYCLES   = 1,
    parameter int unsigned RECOVERY_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       write,
    input  logic       a0,
    input  logic [7:0] wdata,
    output logic       idle,
    output logic       last_recover,
    output logic       chip_select_n,
    output logic       read_enable_n,
    output logic       write_enable_n,
    output logic       address,
    output logic [7:0] data_bus_out,
    output logic       data_bus_oe,
    input  logic [7:0] data_bus_in,
    output logic       rsp_valid,
    output logic [7:0] rsp_data
);

    bus_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            cnt_zero;
    logic            write_q, a0_q;
    logic [7:0]      data_q;
    logic            rsp_valid_q;
    logic [7:0]      rsp_data_q;
    logic            capture;

    assign cnt_zero = (cnt_q == '0);
    assign capture  = (state_q == StStrobe) && cnt_zero && !write_q;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSetup;
                    cnt_d   = load_cnt(SETUP_CYCLES);
                end
            end
            StSetup: begin
                if (cnt_zero) begin
                    state_d = StStrobe;
                    cnt_d   = load_cnt(STROBE_CYCLES);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StStrobe: begin
                if (cnt_zero) begin
                    state_d = StRecover;
                    cnt_d   = load_cnt(RECOVERY_CYCLES);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StRecover: begin
                if (cnt_zero) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Bus outputs, decoded from registered state only
    always_comb begin
        chip_select_n  = 1'b1;
        read_enable_n  = 1'b1;
        write_enable_n = 1'b1;
        data_bus_oe    = 1'b0;
        case (state_q)
            StSetup: begin
                chip_select_n = 1'b0;
                data_bus_oe   = write_q;
            end
            StStrobe: begin
                chip_select_n  = 1'b0;
                write_enable_n = !write_q;
                read_enable_n  = write_q;
                data_bus_oe    = write_q;
            end
            // Hold write data for the first recovery cycle only
            StRecover: data_bus_oe = write_q && (cnt_q == load_cnt(RECOVERY_CYCLES));
            default: ;
        endcase
    end

    // Transaction attributes and read capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_q     <= 1'b0;
            a0_q        <= 1'b0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            if (state_q == StIdle && start) begin
                write_q <= write;
                a0_q    <= a0;
                if (write) begin
                    data_q <= wdata;
                end
            end
            rsp_valid_q <= capture;
            if (capture) begin
                rsp_data_q <= data_bus_in;
            end
        end
    end

    assign idle         = (state_q == StIdle);
    assign last_recover = (state_q == StRecover) && cnt_zero;
    assign address      = a0_q;
    assign data_bus_out = data_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        assert (SETUP_CYCLES >= MinCycles && SETUP_CYCLES <= MaxCycles &&
                STROBE_CYCLES >= MinCycles && STROBE_CYCLES <= MaxCycles &&
                RECOVERY_CYCLES >= MinCycles && RECOVERY_CYCLES <= MaxCycles)
            else $error("pic_bus_cycle_gen: timing parameter outside 1..15");
    end
`endif

endmodule

// File: rtl/pic_bus_initiator.sv
// CPU-side 8259A bus master: single read/write requests plus an ICW1..ICW4 init sequencer.
// Ports:
//   clock, reset_n                    : clock, asynchronous active-low reset
//   req_valid/ready/write/a0/data     : single-transaction command port
//   rsp_valid, rsp_data               : read data pulse / held read data
//   init_start, icw1..icw4            : start ICW sequence with these words
//   init_busy, init_done, init_error  : sequence status
//   chip_select_n, read_enable_n, write_enable_n, address : bus control
//   data_bus_out, data_bus_oe, data_bus_in                : data bus
module pic_bus_initiator
    import pic_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES    = 1,
    parameter int unsigned STROBE_CYCLES   = 1,
    parameter int unsigned RECOVERY_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_a0,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       init_start,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    output logic       init_busy,
    output logic       init_done,
    output logic       init_error,
    output logic       chip_select_n,
    output logic       read_enable_n,
    output logic       write_enable_n,
    output logic       address,
    output logic [7:0] data_bus_out,
    output logic       data_bus_oe,
    input  logic [7:0] data_bus_in
);

    logic       gen_idle, gen_last_recover, gen_start, gen_write, gen_a0;
    logic [7:0] gen_data;
    logic       init_busy_q, init_done_q, init_error_q;
    logic [7:0] icw1_q, icw2_q, icw3_q, icw4_q;
    // One bit per ICW still to be written, bit 0 = ICW1
    logic [3:0] pend_q, pend_d;
    logic       init_accept, init_issue, req_accept;
    logic       issue_a0;
    logic [7:0] issue_word;

    // init_start wins over a request in the same IDLE cycle
    assign init_accept = gen_idle && !init_busy_q && init_start;
    assign req_ready   = gen_idle && !init_busy_q && !init_start;
    assign req_accept  = req_valid && req_ready;
    assign init_issue  = init_busy_q && gen_idle && (pend_q != '0);

    // Lowest pending ICW goes next; only ICW1 uses A0=0
    always_comb begin
        issue_a0   = 1'b1;
        issue_word = icw4_q;
        if (pend_q[0]) begin
            issue_a0   = 1'b0;
            issue_word = icw1_q;
        end else if (pend_q[1]) begin
            issue_word = icw2_q;
        end else if (pend_q[2]) begin
            issue_word = icw3_q;
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (init_accept) begin
            pend_d = icw1[ICW1_ID] ? {icw1[IC4], !icw1[SNGL], 2'b11} : 4'b0000;
        end else if (init_issue) begin
            pend_d = pend_q & (pend_q - 4'd1);  // clear lowest set bit
        end
    end

    assign gen_start = init_issue || req_accept;
    assign gen_write = init_issue ? 1'b1 : req_write;
    assign gen_a0    = init_issue ? issue_a0 : req_a0;
    assign gen_data  = init_issue ? issue_word : req_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            init_busy_q  <= 1'b0;
            init_done_q  <= 1'b0;
            init_error_q <= 1'b0;
            pend_q       <= '0;
            icw1_q       <= '0;
            icw2_q       <= '0;
            icw3_q       <= '0;
            icw4_q       <= '0;
        end else begin
            init_done_q  <= 1'b0;
            init_error_q <= 1'b0;
            pend_q       <= pend_d;
            if (init_accept) begin
                icw1_q <= icw1;
                icw2_q <= icw2;
                icw3_q <= icw3;
                icw4_q <= icw4;
                if (icw1[ICW1_ID]) begin
                    init_busy_q <= 1'b1;
                end else begin
                    init_error_q <= 1'b1;
                end
            end else if (init_busy_q && gen_last_recover && pend_q == '0) begin
                init_busy_q <= 1'b0;
                init_done_q <= 1'b1;
            end
        end
    end

    assign init_busy  = init_busy_q;
    assign init_done  = init_done_q;
    assign init_error = init_error_q;

    pic_bus_cycle_gen #(
        .SETUP_CYCLES   (SETUP_CYCLES),
        .STROBE_CYCLES  (STROBE_CYCLES),
        .RECOVERY_CYCLES(RECOVERY_CYCLES)
    ) u_cycle_gen (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (gen_start),
        .write         (gen_write),
        .a0            (gen_a0),
        .wdata         (gen_data),
        .idle          (gen_idle),
        .last_recover  (gen_last_recover),
        .chip_select_n (chip_select_n),
        .read_enable_n (read_enable_n),
        .write_enable_n(write_enable_n),
        .address       (address),
        .data_bus_out  (data_bus_out),
        .data_bus_oe   (data_bus_oe),
        .data_bus_in   (data_bus_in),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data)
    );

endmodule

// File: tb/tb_pic_bus_initiator.sv
module tb_pic_bus_initiator;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    always #5 clock = ~clock;

    // Default-timing DUT
    logic       req_valid = 0, req_write = 0, req_a0 = 0;
    logic [7:0] req_data = 0;
    logic       req_ready, rsp_valid;
    logic [7:0] rsp_data;
    logic       init_start = 0;
    logic [7:0] icw1 = 0, icw2 = 0, icw3 = 0, icw4 = 0;
    logic       init_busy, init_done, init_error;
    logic       chip_select_n, read_enable_n, write_enable_n, address, data_bus_oe;
    logic [7:0] data_bus_out;
    logic [7:0] data_bus_in = 0;

    // Slow-timing DUT (3/2/2)
    logic       req_valid_s = 0, req_write_s = 0, req_a0_s = 0;
    logic [7:0] req_data_s = 0;
    logic       req_ready_s, rsp_valid_s;
    logic [7:0] rsp_data_s;
    logic       init_start_s = 0;
    logic [7:0] icw_zero = 0;
    logic       init_busy_s, init_done_s, init_error_s;
    logic       cs_n_s, re_n_s, we_n_s, address_s, oe_s;
    logic [7:0] dbo_s;

    pic_bus_initiator dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_a0(req_a0), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .init_start(init_start), .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
        .init_busy(init_busy), .init_done(init_done), .init_error(init_error),
        .chip_select_n(chip_select_n), .read_enable_n(read_enable_n),
        .write_enable_n(write_enable_n), .address(address), .data_bus_out(data_bus_out),
        .data_bus_oe(data_bus_oe), .data_bus_in(data_bus_in)
    );

    pic_bus_initiator #(
        .SETUP_CYCLES(3), .STROBE_CYCLES(2), .RECOVERY_CYCLES(2)
    ) dut_slow (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid_s), .req_ready(req_ready_s), .req_write(req_write_s),
        .req_a0(req_a0_s), .req_data(req_data_s), .rsp_valid(rsp_valid_s),
        .rsp_data(rsp_data_s), .init_start(init_start_s), .icw1(icw_zero),
        .icw2(icw_zero), .icw3(icw_zero), .icw4(icw_zero), .init_busy(init_busy_s),
        .init_done(init_done_s), .init_error(init_error_s), .chip_select_n(cs_n_s),
        .read_enable_n(re_n_s), .write_enable_n(we_n_s), .address(address_s),
        .data_bus_out(dbo_s), .data_bus_oe(oe_s), .data_bus_in(data_bus_in)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0] last_rd = 8'h00;

    // Scoreboards: {a0, data} per expected write, data per expected read response
    logic [8:0] exp_wr_q[$];
    logic [7:0] exp_rd_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Bus monitor: every write strobe and every read response is matched against the queues
    logic prev_we_n = 1'b1;
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_we_n <= 1'b1;
        end else begin
            if (!write_enable_n && prev_we_n) begin
                if (exp_wr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL wr_unexpected: got a0=%0d data=%0h, required no write",
                             address, data_bus_out);
                end else begin
                    logic [8:0] e;
                    e = exp_wr_q.pop_front();
                    check("wr_a0", 32'(address), 32'(e[8]));
                    check("wr_data", 32'(data_bus_out), 32'(e[7:0]));
                    check("wr_oe", 32'(data_bus_oe), 1);
                    check("wr_cs", 32'(chip_select_n), 0);
                end
            end
            if (rsp_valid) begin
                if (exp_rd_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_unexpected: got data=%0h, required no response", rsp_data);
                end else begin
                    logic [7:0] r;
                    r = exp_rd_q.pop_front();
                    check("rsp_data", 32'(rsp_data), 32'(r));
                end
            end
            prev_we_n <= write_enable_n;
        end
    end

    typedef struct {
        logic       wr;
        logic       a0;
        logic [7:0] data;
        logic [7:0] bus_in;
        int         exp_cycles;  // negedges after accept until req_ready returns
        int         exp_cs;      // cycles with chip_select_n low
        int         exp_st;      // cycles with the relevant strobe low
        int         exp_oe;      // cycles with data_bus_oe high
        int         exp_rsp;     // rsp_valid pulse cycles
    } req_vec_t;

    task automatic do_req(input req_vec_t v);
        int cs_low = 0, st_low = 0, wrong_st = 0, oe_cyc = 0, rsp_cyc = 0, ready_at = 0;
        if (v.wr) exp_wr_q.push_back({v.a0, v.data});
        else exp_rd_q.push_back(v.bus_in);
        req_valid = 1; req_write = v.wr; req_a0 = v.a0; req_data = v.data;
        data_bus_in = v.bus_in;
        @(posedge clock); #1;
        req_valid = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (req_ready) begin
                ready_at = n;
                break;
            end
            if (!chip_select_n) cs_low++;
            if (!(v.wr ? write_enable_n : read_enable_n)) begin
                st_low++;
                check("strobe_a0", 32'(address), 32'(v.a0));
            end
            if (!(v.wr ? read_enable_n : write_enable_n)) wrong_st++;
            if (data_bus_oe) oe_cyc++;
            if (rsp_valid) rsp_cyc++;
        end
        check("req_cycles", ready_at, v.exp_cycles);
        check("cs_low_cycles", cs_low, v.exp_cs);
        check("strobe_low_cycles", st_low, v.exp_st);
        check("wrong_strobe_cycles", wrong_st, 0);
        check("oe_cycles", oe_cyc, v.exp_oe);
        check("rsp_pulse_cycles", rsp_cyc, v.exp_rsp);
        if (!v.wr) last_rd = v.bus_in;
        check("rsp_data_held", 32'(rsp_data), 32'(last_rd));
        @(posedge clock); #1;
    endtask

    task automatic do_init(input logic [7:0] i1, input logic [7:0] i2, input logic [7:0] i3,
                           input logic [7:0] i4, input logic with_req);
        int n_exp = 0, done_at = 0, cs_falls = 0, ready_at = 0;
        logic prev_cs = 1'b1;
        exp_wr_q.push_back({1'b0, i1}); n_exp++;
        exp_wr_q.push_back({1'b1, i2}); n_exp++;
        if (!i1[1]) begin exp_wr_q.push_back({1'b1, i3}); n_exp++; end
        if (i1[0]) begin exp_wr_q.push_back({1'b1, i4}); n_exp++; end
        if (with_req) exp_wr_q.push_back({1'b0, 8'hEE});
        icw1 = i1; icw2 = i2; icw3 = i3; icw4 = i4;
        init_start = 1;
        if (with_req) begin
            req_valid = 1; req_write = 1; req_a0 = 0; req_data = 8'hEE;
        end
        @(negedge clock);
        check("init_accept_ready", 32'(req_ready), 0);
        @(posedge clock); #1;
        init_start = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clock);
            if (!chip_select_n && prev_cs) cs_falls++;
            prev_cs = chip_select_n;
            if (init_done) begin
                done_at = n;
                check("done_busy_low", 32'(init_busy), 0);
                check("done_ready", 32'(req_ready), 1);
                break;
            end
            check("init_busy_high", 32'(init_busy), 1);
            check("init_ready_low", 32'(req_ready), 0);
        end
        check("init_done_cycle", done_at, 4 * n_exp + 1);
        check("init_write_count", cs_falls, n_exp);
        @(negedge clock);
        check("init_done_pulse", 32'(init_done), 0);
        if (with_req) begin
            check("held_req_started", 32'(chip_select_n), 0);
            req_valid = 0;
            for (int n = 1; n <= 10; n++) begin
                @(negedge clock);
                if (req_ready) begin
                    ready_at = n;
                    break;
                end
            end
            check("held_req_done", ready_at, 3);
        end
        @(posedge clock); #1;
    endtask

    req_vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cs_low, we_low, first_cs, first_we, ready_at, err_cyc;

        vecs[0] = '{1'b1, 1'b0, 8'h10, 8'h00, 4, 2, 1, 3, 0};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 8'hA5, 4, 2, 1, 0, 1};
        vecs[2] = '{1'b1, 1'b1, 8'hFF, 8'h00, 4, 2, 1, 3, 0};
        vecs[3] = '{1'b0, 1'b0, 8'h77, 8'h3C, 4, 2, 1, 0, 1};
        vecs[4] = '{1'b1, 1'b0, 8'h00, 8'h5A, 4, 2, 1, 3, 0};

        // Reset state
        #12;
        check("rst_cs_n", 32'(chip_select_n), 1);
        check("rst_re_n", 32'(read_enable_n), 1);
        check("rst_we_n", 32'(write_enable_n), 1);
        check("rst_address", 32'(address), 0);
        check("rst_data_out", 32'(data_bus_out), 0);
        check("rst_oe", 32'(data_bus_oe), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_init_flags", 32'({init_busy, init_done, init_error}), 0);
        @(posedge clock); #1;
        reset_n = 1;
        @(negedge clock);
        check("rst_ready", 32'(req_ready), 1);
        @(posedge clock); #1;

        // Reset in the middle of a write strobe
        req_valid = 1; req_write = 1; req_a0 = 1; req_data = 8'h5A;
        @(posedge clock); #1;
        req_valid = 0;
        @(posedge clock); #1;
        check("abort_we_low", 32'(write_enable_n), 0);
        #1 reset_n = 0;
        #1;
        check("abort_we_n", 32'(write_enable_n), 1);
        check("abort_cs_n", 32'(chip_select_n), 1);
        check("abort_oe", 32'(data_bus_oe), 0);
        @(posedge clock); #1;
        reset_n = 1;
        @(negedge clock);
        check("abort_ready", 32'(req_ready), 1);
        check("abort_idle_cs", 32'(chip_select_n), 1);
        @(posedge clock); #1;

        // Single transactions
        for (int i = 0; i < 5; i++) do_req(vecs[i]);

        // ICW sequences
        do_init(8'h13, 8'h20, 8'hAA, 8'h01, 1'b0);
        do_init(8'h10, 8'h08, 8'h04, 8'h55, 1'b1);

        // ICW1 without the ID bit
        icw1 = 8'h03;
        init_start = 1;
        @(posedge clock); #1;
        init_start = 0;
        @(negedge clock);
        check("err_pulse", 32'(init_error), 1);
        check("err_busy", 32'(init_busy), 0);
        cs_low = 0; err_cyc = 0;
        for (int n = 0; n < 6; n++) begin
            if (!chip_select_n) cs_low++;
            @(negedge clock);
            if (init_error) err_cyc++;
        end
        check("err_no_bus", cs_low, 0);
        check("err_single_pulse", err_cyc, 0);
        check("err_ready", 32'(req_ready), 1);
        @(posedge clock); #1;

        // Slow timing write
        req_valid_s = 1; req_write_s = 1; req_a0_s = 1; req_data_s = 8'hC3;
        @(posedge clock); #1;
        req_valid_s = 0;
        cs_low = 0; we_low = 0; first_cs = 0; first_we = 0; ready_at = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (req_ready_s) begin
                ready_at = n;
                break;
            end
            if (!cs_n_s) begin
                cs_low++;
                if (first_cs == 0) first_cs = n;
            end
            if (!we_n_s) begin
                we_low++;
                if (first_we == 0) first_we = n;
                check("slow_wr_data", 32'({address_s, dbo_s}), 32'({1'b1, 8'hC3}));
            end
        end
        check("slow_cs_low", cs_low, 5);
        check("slow_we_low", we_low, 2);
        check("slow_we_offset", first_we - first_cs, 3);
        check("slow_cycles", ready_at, 8);

        check("wr_queue_empty", exp_wr_q.size(), 0);
        check("rd_queue_empty", exp_rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pic_bus_initiator.md
Name: pic_bus_initiator

Overview:
CPU-side bus master for the 8259A bus interface. It generates chip_select_n, read_enable_n, write_enable_n, address (A0) and the data bus with programmable setup, strobe and recovery timing.
- Serves single read/write requests from a valid/ready command port.
- Contains an ICW1..ICW4 initialization sequencer that skips ICW3/ICW4 according to ICW1.
- Drives the PIC's data bus buffer / read-write logic in system-level benches and in the CPU-model wrapper.

Parameters:
SETUP_CYCLES, 1, cycles with chip_select_n low and address/data stable before the strobe; legal range 1..15
STROBE_CYCLES, 1, cycles read_enable_n or write_enable_n is held low; legal range 1..15
RECOVERY_CYCLES, 1, cycles with all strobes high between transactions; legal range 1..15

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  single-transaction request
req_ready  out  1  high when in IDLE and no init sequence is running (combinational from state)
req_write  in  1  1 = write, 0 = read
req_a0  in  1  A0 value for the request
req_data  in  8  write data
rsp_valid  out  1  one-cycle pulse carrying read data
rsp_data  out  8  captured read data, held until the next read
init_start  in  1  start the ICW sequence (sampled in IDLE only)
icw1, icw2, icw3, icw4  in  8 each  initialization words, sampled at init start
init_busy  out  1  high from init accept until the last ICW recovery completes
init_done  out  1  one-cycle pulse at the end of the sequence
init_error  out  1  one-cycle pulse when icw1[4]=0; no bus cycles are issued
chip_select_n  out  1  active-low chip select
read_enable_n  out  1  active-low read strobe
write_enable_n  out  1  active-low write strobe
address  out  1  A0
data_bus_out  out  8  write data
data_bus_oe  out  1  data_bus_out output enable
data_bus_in  in  8  read data from the PIC

Behaviour:
- Reset (async, reset_n=0): state IDLE; all counters cleared; init aborted.
  - chip_select_n, read_enable_n, write_enable_n = 1.
  - address = 0, data_bus_out = 0, data_bus_oe = 0.
  - rsp_valid, rsp_data = 0; init_busy, init_done, init_error = 0.
  - Reset mid-transaction deasserts the strobes immediately, with no recovery phase.
- All bus outputs are registered; the FSM is IDLE -> SETUP -> STROBE -> RECOVER -> IDLE.
- Accept: at the rising edge where state=IDLE.
  - init_start=1 takes priority over req_valid. req_ready is 0 during that cycle's decision, so the request is not consumed.
  - Otherwise req_valid=1 and req_ready=1 accepts the request.
- SETUP, SETUP_CYCLES cycles:
  - chip_select_n=0 and address driven.
  - For writes, data_bus_out is driven and data_bus_oe=1.
  - Strobes stay high.
- STROBE, STROBE_CYCLES cycles: write_enable_n=0 (write) or read_enable_n=0 (read). chip_select_n, address and data are held.
- Read capture: data_bus_in is registered into rsp_data at the clock edge that ends the last STROBE cycle. rsp_valid pulses for exactly the first RECOVER cycle.
- RECOVER, RECOVERY_CYCLES cycles:
  - All strobes and chip_select_n = 1.
  - data_bus_oe stays 1 for the first RECOVER cycle (data hold), then drops to 0.
- Transaction length is SETUP+STROBE+RECOVERY cycles, plus 1 IDLE cycle before the next accept. With defaults this is 4 cycles per transaction.
- Init sequence: icw1..icw4 are latched on accept and init_busy goes to 1.
  - If icw1[4]=0: pulse init_error, clear init_busy, return to IDLE. No bus activity.
  - Otherwise issue, back to back (each with one IDLE gap cycle):
    1. ICW1 with A0=0.
    2. ICW2 with A0=1.
    3. ICW3 with A0=1, only if icw1[1]=0 (cascade).
    4. ICW4 with A0=1, only if icw1[0]=1 (IC4).
  - init_done pulses in the cycle after the last RECOVER. init_busy falls in that same cycle.
  - req_ready stays 0 for the whole sequence.
- init_start while init_busy=1 or mid-transaction: ignored; it is not queued.
- Counters are sized to $clog2(16) bits. Parameter value 0 is illegal; simulation asserts the 1..15 range.

Decomposition:
- Shared package pic_bus_pkg:
  - FSM state encoding (IDLE, SETUP, STROBE, RECOVER).
  - ICW1 bit-index constants: IC4=0, SNGL=1, ICW1_ID=4.
  - Timing-range constants.
- One sub-module, pic_bus_cycle_gen: single-transaction timing FSM plus counters.
- Top level pic_bus_initiator holds the request mux and the ICW sequencer.

Test Plan:
1. Reset with reset_n=0 mid-STROBE of a write -> write_enable_n and chip_select_n go to 1 asynchronously, data_bus_oe=0, and req_ready=1 after release.
2. Write request a0=0, data=8'h10 (defaults) -> chip_select_n low for 2 cycles, write_enable_n low exactly in the 2nd, address=0, data_bus_out=8'h10, req_ready back to 1 after 4 cycles.
3. Read request a0=1 with data_bus_in=8'hA5 -> read_enable_n low for 1 cycle, rsp_valid a single-cycle pulse, rsp_data=8'hA5.
4. init_start with icw1=8'h13, icw2=8'h20, icw4=8'h01 -> 3 writes: (A0=0, 8'h13), (A0=1, 8'h20), (A0=1, 8'h01); no ICW3; init_done 1 cycle after 12 bus cycles.
5. init_start with icw1=8'h10, icw2=8'h08, icw3=8'h04 -> 3 writes (ICW1, ICW2, ICW3) and no ICW4. A simultaneous req_valid is not accepted until init_busy=0.
6. icw1=8'h03 -> init_error pulse with no chip_select_n activity. Then SETUP_CYCLES=3, STROBE_CYCLES=2, RECOVERY_CYCLES=2 on a write -> chip_select_n low 5 cycles, write_enable_n low the last 2.
